// File: rtl/result_uart_streamer_pkg.sv
// rtl/result_uart_streamer_pkg.sv - shared types and constants for the result UART streamer
package result_uart_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE, SEND_SYNC, FETCH, WAIT_RD, LOAD, SEND_DATA, SEND_CSUM, FINISH
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE, HS_SEND, HS_ACK
  } hs_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int frame_len(input int n_entries, input int data_w);
    return 2 + n_entries * (data_w / 8);
  endfunction

endpackage

// File: rtl/uart_byte_handshake.sv
// rtl/uart_byte_handshake.sv - three-phase start/busy byte send towards uart_tx
module uart_byte_handshake
  import result_uart_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] byte_data,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       ack
);

  hs_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HS_IDLE;
      tx_data  <= '0;
      tx_start <= 1'b0;
      ack      <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        // Only a busy low seen before raising start lets the next busy high count as acceptance.
        HS_IDLE: if (req && !tx_busy) begin
          tx_data  <= byte_data;
          tx_start <= 1'b1;
          state    <= HS_SEND;
        end
        HS_SEND: if (tx_busy) begin
          tx_start <= 1'b0;
          ack      <= 1'b1;
          state    <= HS_ACK;
        end
        // req is still high while the requester reacts to ack; skip that cycle.
        HS_ACK:  state <= HS_IDLE;
        default: state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/result_uart_streamer.sv
// rtl/result_uart_streamer.sv - streams the result matrix to uart_tx as SYNC, data bytes, XOR checksum
module result_uart_streamer
  import result_uart_streamer_pkg::*;
#(
  parameter int         N_ENTRIES = 16,
  parameter int         ADDR_W    = 4,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_ENTRIES - 1);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] word_idx;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [7:0]        checksum;
  logic [7:0]        byte_data;
  logic              req;
  logic              ack;

  assign req = (state == SEND_SYNC) || (state == SEND_DATA) || (state == SEND_CSUM);

  always_comb begin
    byte_data = shift_reg[DATA_W-1 -: 8];
    case (state)
      SEND_SYNC: byte_data = SYNC_BYTE;
      SEND_CSUM: byte_data = checksum;
      default:   byte_data = shift_reg[DATA_W-1 -: 8];
    endcase
  end

  uart_byte_handshake u_hs (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .byte_data (byte_data),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .ack       (ack)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          checksum <= '0;
          word_idx <= '0;
          state    <= SEND_SYNC;
        end
        SEND_SYNC: if (ack) state <= FETCH;
        FETCH: begin
          rd_addr <= word_idx;
          state   <= WAIT_RD;
        end
        WAIT_RD: state <= LOAD;
        LOAD: begin
          shift_reg <= rd_data;
          byte_cnt  <= LAST_BYTE;
          state     <= SEND_DATA;
        end
        SEND_DATA: if (ack) begin
          checksum  <= checksum ^ shift_reg[DATA_W-1 -: 8];
          shift_reg <= shift_reg << 8;
          if (byte_cnt == '0) begin
            if (word_idx == LAST_IDX) begin
              state <= SEND_CSUM;
            end else begin
              word_idx <= word_idx + ADDR_W'(1);
              state    <= FETCH;
            end
          end else begin
            byte_cnt <= byte_cnt - BC_W'(1);
          end
        end
        // done and busy change together, so a start during the done cycle lands in FINISH and is dropped.
        SEND_CSUM: if (ack) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_streamer.sv
// tb/tb_result_uart_streamer.sv - directed self-checking bench for result_uart_streamer
module tb_result_uart_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [3:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_data = '0;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_start0, tx_start1, busy0, busy1, done0, done1;
  logic        tx_busy, tx_busy0, tx_busy1;
  logic        sel = 1'b0;
  logic        m_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic [31:0] mem [16];
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  logic [3:0]  addr_q [$];
  logic [3:0]  prev_addr = '0;
  int          vectors = 0, errors = 0;
  int          done_cnt = 0, stab_err = 0;
  int          busy_delay = 1, busy_len = 3;
  int          m_state = 0, dly = 0, bl = 0;
  logic [7:0]  held = '0;
  logic        m_start;
  logic [7:0]  m_data;

  always #5 clk = ~clk;

  result_uart_streamer u0 (
    .clk(clk), .rst(rst), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data),
    .tx_data(tx_data0), .tx_start(tx_start0), .tx_busy(tx_busy0), .busy(busy0), .done(done0)
  );

  result_uart_streamer #(.N_ENTRIES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data),
    .tx_data(tx_data1), .tx_start(tx_start1), .tx_busy(tx_busy1), .busy(busy1), .done(done1)
  );

  assign tx_busy  = m_busy | force_busy;
  assign tx_busy0 = sel ? 1'b0 : tx_busy;
  assign tx_busy1 = sel ? tx_busy : 1'b0;
  assign m_start  = sel ? tx_start1 : tx_start0;
  assign m_data   = sel ? tx_data1 : tx_data0;

  always @(posedge clk) rd_data <= mem[sel ? rd_addr1 : rd_addr0];

  always @(posedge clk) begin
    if (sel ? done1 : done0) done_cnt++;
    if (rd_addr0 !== prev_addr) addr_q.push_back(rd_addr0);
    prev_addr = rd_addr0;
  end

  // uart_tx model: raises busy busy_delay cycles after start, holds it busy_len cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_busy <= 1'b0;
    end else begin
      case (m_state)
        0: if (m_start && !tx_busy) begin
          held = m_data; dly = busy_delay; m_state = 1;
        end
        1: begin
          if (!m_start || m_data !== held) stab_err++;
          if (dly <= 1) begin
            m_busy <= 1'b1; rx_q.push_back(held); bl = busy_len; m_state = 2;
          end else dly--;
        end
        default: if (bl <= 1) begin
          m_busy <= 1'b0; m_state = 0;
        end else bl--;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int n);
    logic [7:0] v, cs;
    cs = '0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int w = 0; w < n; w++)
      for (int b = 3; b >= 0; b--) begin
        v = mem[w][b*8 +: 8];
        exp_q.push_back(v);
        cs ^= v;
      end
    exp_q.push_back(cs);
  endtask

  task automatic check_frame(input string tag, input int n_bytes);
    int mis;
    mis = 0;
    chk({tag, "_len"}, rx_q.size(), n_bytes);
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mis++;
    chk({tag, "_bytes_wrong"}, mis, 0);
  endtask

  task automatic pulse_start0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int i;
    i = 0;
    while (done_cnt == base && i < 4000) begin @(negedge clk); i++; end
    chk({tag, "_done_seen"}, done_cnt > base, 1);
    repeat (5) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt - base, 1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int base, viol, i;

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_u0", {rd_addr0, tx_data0, tx_start0, busy0, done0}, 0);
    chk("reset_outputs_u1", {rd_addr1, tx_data1, tx_start1, busy1, done1}, 0);
    rst = 1'b0;

    // single-word frame on the N_ENTRIES=1 instance
    sel = 1'b1; busy_delay = 2; busy_len = 10;
    mem[0] = 32'hDEADBEEF;
    rx_q.delete(); base = done_cnt;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("n1_busy_after_start", busy1, 1);
    wait_done("n1", base);
    exp_q = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    check_frame("n1_frame", 6);
    chk("n1_busy_low_after", busy1, 0);
    sel = 1'b0;

    // full frame, mem[i] = i+1, rd_addr sequence
    for (int k = 0; k < 16; k++) mem[k] = k + 1;
    busy_delay = 1; busy_len = 3;
    do_reset();
    rx_q.delete(); addr_q.delete(); stab_err = 0; base = done_cnt;
    pulse_start0();
    wait_done("full", base);
    build_exp(16);
    check_frame("full_frame", 66);
    chk("full_checksum", rx_q.size() == 66 ? rx_q[65] : 8'hxx, 8'h10);
    chk("full_addr_changes", addr_q.size(), 15);
    viol = 0;
    for (int k = 0; k < addr_q.size(); k++) if (addr_q[k] !== 4'(k + 1)) viol++;
    chk("full_addr_order", viol, 0);
    chk("full_stability", stab_err, 0);

    // tx_busy held high before start
    for (int k = 0; k < 16; k++) mem[k] = 32'h1357_9BDF * (k + 3);
    build_exp(16);
    rx_q.delete(); stab_err = 0; base = done_cnt;
    @(negedge clk) force_busy = 1'b1;
    pulse_start0();
    viol = 0;
    repeat (50) @(negedge clk) if (tx_start0) viol++;
    chk("stale_busy_no_start", viol, 0);
    chk("stale_busy_frame_busy", busy0, 1);
    force_busy = 1'b0;
    wait_done("stale", base);
    check_frame("stale_frame", 66);
    chk("stale_stability", stab_err, 0);

    // extra start at byte 20 is ignored
    rx_q.delete(); base = done_cnt;
    pulse_start0();
    i = 0;
    while (rx_q.size() < 20 && i < 2000) begin @(negedge clk); i++; end
    chk("mid_reached_byte20", rx_q.size() >= 20, 1);
    pulse_start0();
    wait_done("mid", base);
    check_frame("mid_frame", 66);
    repeat (10) @(negedge clk);
    chk("mid_no_queued_frame", busy0, 0);

    // async reset while tx_start is high
    rx_q.delete();
    pulse_start0();
    i = 0;
    while (!(rx_q.size() >= 5 && tx_start0) && i < 2000) begin @(negedge clk); i++; end
    chk("rst_mid_tx_start_seen", tx_start0, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", {rd_addr0, tx_data0, tx_start0, busy0, done0}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_partial_byte", tx_start0, 0);
    rx_q.delete(); base = done_cnt;
    pulse_start0();
    wait_done("rst_fresh", base);
    check_frame("rst_fresh_frame", 66);

    // start on the done cycle is dropped, start on the next cycle is taken
    rx_q.delete(); base = done_cnt;
    pulse_start0();
    i = 0;
    while (!done0 && i < 4000) begin @(negedge clk); i++; end
    chk("done_cycle_seen", done0, 1);
    start0 = 1'b1;
    rx_q.delete();
    @(negedge clk);
    chk("start_on_done_ignored", busy0, 0);
    @(negedge clk);
    chk("start_next_cycle_taken", busy0, 1);
    start0 = 1'b0;
    base = done_cnt;
    wait_done("after_done", base);
    check_frame("after_done_frame", 66);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/result_uart_streamer.md
Name: result_uart_streamer

Overview:
Reads the result matrix out of the result matrix_memory after multiplication completes and streams it to the UART transmitter as a framed byte sequence. It is the transmit-side counterpart of the receive/store path that loads matrices A and B from uart_rx.
Frame format: SYNC byte, then every result word serialized MSB-first, then a one-byte XOR checksum.
It sits between result_mem (synchronous read port) and uart_tx (start/busy handshake), and is triggered by control_unit.

Parameters:
N_ENTRIES, 16, number of result words sent per frame (1..2**ADDR_W)
ADDR_W, 4, result memory address width
DATA_W, 32, result word width; must be a multiple of 8
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse from control_unit; begins a frame when idle
rd_addr  output  ADDR_W  result memory read address
rd_data  input  DATA_W  result memory read data, valid 1 cycle after rd_addr
tx_data  output  8  byte presented to uart_tx
tx_start  output  1  request to uart_tx; held until tx_busy observed high
tx_busy  input  1  uart_tx busy flag
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the checksum byte is accepted

Behaviour:
- Reset (async, any state): state=IDLE, rd_addr=0, tx_data=0, tx_start=0, busy=0, done=0, checksum=0, word/byte counters=0. Any frame in flight is abandoned. No partial byte is requested after reset.
- States: IDLE, SEND_SYNC, FETCH, WAIT_RD, LOAD, SEND_DATA, SEND_CSUM, FINISH.
- IDLE: start=1 -> SEND_SYNC; busy=1 next cycle; checksum cleared; word index=0.
- start while busy=1 is ignored; it is neither queued nor able to restart the frame.
- Byte send sub-protocol, shared by SEND_SYNC, SEND_DATA and SEND_CSUM:
  - Phase A: wait while tx_busy=1. A stale busy from a prior transfer is never taken as acknowledgement.
  - Phase B: drive tx_data and tx_start=1, holding both stable.
  - Phase C: the first cycle tx_busy=1 is the acceptance. Drop tx_start next cycle; the byte is then complete.
  - tx_data must not change while tx_start=1.
- SEND_SYNC: sends SYNC_BYTE. The SYNC byte is not included in the checksum. Then -> FETCH.
- FETCH: rd_addr=word index -> WAIT_RD (1-cycle memory latency) -> LOAD. LOAD captures rd_data into a DATA_W shift register and sets byte counter=DATA_W/8-1.
- SEND_DATA: sends shift_reg[DATA_W-1 -: 8], i.e. MSB first.
  - On acceptance: checksum ^= byte, shift left by 8.
  - If the byte counter is 0: when the word index is N_ENTRIES-1 -> SEND_CSUM; otherwise index+1 -> FETCH.
  - Otherwise decrement the byte counter and send the next byte.
- rd_addr is stable from FETCH until the next FETCH; the word index never wraps within a frame.
- SEND_CSUM: sends the checksum byte -> FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 the same cycle -> IDLE. A start coincident with the done cycle is ignored; start is accepted from the following cycle.
- Frame length is 2 + N_ENTRIES*DATA_W/8 bytes (66 at defaults). Throughput is limited only by tx_busy.
- If tx_busy stays high forever, the block waits indefinitely; there is no timeout.

Decomposition:
- Shared package: FSM state encoding typedef, SYNC_BYTE default, frame-length constant function of (N_ENTRIES, DATA_W).
- One natural sub-module, uart_byte_handshake: implements the start/busy three-phase send.
  - Inputs: req, byte.
  - Outputs: tx_data, tx_start, ack (one-cycle pulse on acceptance).
  - The streamer FSM issues req and waits for ack.

Test Plan:
- N_ENTRIES=1, mem[0]=32'hDEADBEEF, tx model asserts busy 2 cycles after start for 10 cycles -> bytes A5,DE,AD,BE,EF,22; one done pulse; busy low afterward.
- Defaults, mem[i]=i+1 -> 66 bytes: A5, then 00,00,00,01 … 00,00,00,10, then checksum 10; rd_addr visits 0..15 in order, once each.
- tx_busy held high 50 cycles before start -> tx_start stays 0 until busy falls, then SYNC sent. tx_start/tx_data stable until the acceptance edge.
- start pulsed again mid-frame (byte 20) -> frame continues unchanged, still 66 bytes, single done.
- rst asserted mid-byte while tx_start=1 -> all outputs 0 immediately (async). A later start produces a complete fresh frame beginning with A5 and a correct checksum.
- start pulsed on the done cycle -> ignored; start on the next cycle -> new frame begins.
